h6_mul_sequencer: RTL

- Controller that sequences H6_module through one complete multiply, so a caller (ALU top or board interface) only issues start and waits for done.
- Drives H6 operation select (inTWO/inTHREE/inFOUR), input bus select (MUL1/MUL2_1/MUL2_2), the register step clock (inQLK) and output enables (ALS_H6_a/ALS_H6_q).
- Sequence: load A from A_bus, load Q from B_bus, ITER multiply steps, then result drive.
- Sits between the ALU decoder and H6_module; replaces manual KEY stepping.

---
 rtl/h6_mul_sequencer_if.sv | 31 +++
 rtl/h6_mul_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/h6_mul_sequencer_if.sv
// Control/handshake bundle between the caller, h6_mul_sequencer and H6_module.
// master: the sequencer (drives H6 controls and status, receives start/step_en).
// slave : the caller / H6 side (drives start/step_en, observes everything else).
interface h6_mul_sequencer_if;
    logic       start;
    logic       step_en;
    logic       inTWO;
    logic       inTHREE;
    logic       inFOUR;
    logic       MUL1;
    logic       MUL2_1;
    logic       MUL2_2;
    logic       inQLK;
    logic       ALS_H6_a;
    logic       ALS_H6_q;
    logic       busy;
    logic       done;
    logic [4:0] step_cnt;

    modport master (
        input  start, step_en,
        output inTWO, inTHREE, inFOUR, MUL1, MUL2_1, MUL2_2, inQLK,
               ALS_H6_a, ALS_H6_q, busy, done, step_cnt
    );

    modport slave (
        output start, step_en,
        input  inTWO, inTHREE, inFOUR, MUL1, MUL2_1, MUL2_2, inQLK,
               ALS_H6_a, ALS_H6_q, busy, done, step_cnt
    );
endinterface

// File: rtl/h6_mul_sequencer.sv
// h6_mul_sequencer: walks H6_module through one full multiply
// (load A, load Q, ITER multiply steps, drive result) from a single start.
// Each op state holds its controls for SETTLE cycles, then pulses inQLK once.
// Optional macro H6_SEQ_SINGLE_STEP_EN: every inQLK pulse and the final done
// wait for a step_en strobe (board debug through a debounced key).
module h6_mul_sequencer #(
    parameter int ITER       = 16,
    parameter int SETTLE     = 2,
    parameter int OUT_CYCLES = 1
) (
    input  logic               CLK_50,
    input  logic               Rst,
    h6_mul_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_Q,
        S_MUL,
        S_OUT
    } state_t;

    localparam logic [3:0] SETTLE_PH = 4'(SETTLE);
    localparam logic [3:0] OUT_LAST  = 4'(OUT_CYCLES - 1);
    localparam logic [4:0] ITER_CNT  = 5'(ITER);

    state_t     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [4:0] step_cnt_q, step_cnt_d;
    logic [2:0] op_q, op_d;
    logic       mul1_q, mul1_d;
    logic       mul2_1_q, mul2_1_d;
    logic       qlk_arm_q, qlk_arm_d;
    logic       als_q, als_d;
    logic       busy_q, busy_d;
    logic       done_arm_q, done_arm_d;
    logic       pulse_ok;

`ifdef H6_SEQ_SINGLE_STEP_EN
    assign pulse_ok = bus.step_en;
`else
    // Free-running: every settle phase fires immediately, step_en has no role.
    logic unused_step_en;
    assign unused_step_en = bus.step_en;
    assign pulse_ok       = 1'b1;
`endif

    // Next state, phase and step count; outputs are decoded from the next
    // state so the registered controls change exactly on phase-0 entry.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        step_cnt_d = step_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD_A;
                    phase_d    = 4'd0;
                    step_cnt_d = 5'd0;
                end
            end
            S_LOAD_A, S_LOAD_Q, S_MUL: begin
                if (phase_q != SETTLE_PH) begin
                    phase_d = phase_q + 4'd1;
                end else if (pulse_ok) begin
                    phase_d = 4'd0;
                    if (state_q == S_LOAD_A) begin
                        state_d = S_LOAD_Q;
                    end else if (state_q == S_LOAD_Q) begin
                        state_d = S_MUL;
                    end else begin
                        step_cnt_d = step_cnt_q + 5'd1;
                        if (step_cnt_q + 5'd1 == ITER_CNT) begin
                            state_d = S_OUT;
                        end
                    end
                end
            end
            S_OUT: begin
                if (phase_q != OUT_LAST) begin
                    phase_d = phase_q + 4'd1;
                end else if (pulse_ok) begin
                    state_d = S_IDLE;
                    phase_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 4'd0;
            end
        endcase

        op_d       = 3'b000;
        mul1_d     = 1'b0;
        mul2_1_d   = 1'b0;
        als_d      = 1'b0;
        busy_d     = (state_d != S_IDLE);
        qlk_arm_d  = 1'b0;
        done_arm_d = 1'b0;
        unique case (state_d)
            S_LOAD_A: mul1_d = 1'b1;
            S_LOAD_Q: begin
                op_d     = 3'b001;
                mul2_1_d = 1'b1;
            end
            S_MUL:    op_d = 3'b110;
            S_OUT: begin
                op_d  = 3'b110;
                als_d = 1'b1;
            end
            default:  op_d = 3'b000;
        endcase
        if ((state_d == S_LOAD_A || state_d == S_LOAD_Q || state_d == S_MUL) &&
            phase_d == SETTLE_PH) begin
            qlk_arm_d = 1'b1;
        end
        if (state_d == S_OUT && phase_d == OUT_LAST) begin
            done_arm_d = 1'b1;
        end
    end

    // State and registered controls; Rst clears everything at once.
    always_ff @(posedge CLK_50 or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 4'd0;
            step_cnt_q <= 5'd0;
            op_q       <= 3'b000;
            mul1_q     <= 1'b0;
            mul2_1_q   <= 1'b0;
            qlk_arm_q  <= 1'b0;
            als_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_arm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            step_cnt_q <= step_cnt_d;
            op_q       <= op_d;
            mul1_q     <= mul1_d;
            mul2_1_q   <= mul2_1_d;
            qlk_arm_q  <= qlk_arm_d;
            als_q      <= als_d;
            busy_q     <= busy_d;
            done_arm_q <= done_arm_d;
        end
    end

    assign bus.inTWO    = op_q[2];
    assign bus.inTHREE  = op_q[1];
    assign bus.inFOUR   = op_q[0];
    assign bus.MUL1     = mul1_q;
    assign bus.MUL2_1   = mul2_1_q;
    assign bus.MUL2_2   = 1'b0;
    assign bus.inQLK    = qlk_arm_q & pulse_ok;
    assign bus.ALS_H6_a = als_q;
    assign bus.ALS_H6_q = als_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_arm_q & pulse_ok;
    assign bus.step_cnt = step_cnt_q;

endmodule
